// File: rtl/ext_pkg.sv
// Shared types for the operand-extension stage:
// mode encoding, skid-buffer states and width helper.
package ext_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SIGN = 3'd1,
    HIGH = 3'd2,
    LB   = 3'd3,
    LBU  = 3'd4,
    LH   = 3'd5,
    LHU  = 3'd6,
    LW   = 3'd7
  } ext_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ext_stage_if.sv
// Valid/ready bundle between the producer, the extension
// stage and its consumer.
interface ext_stage_if
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) ();

  localparam int OFF_W = off_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  ext_mode_e         mode;
  logic [OFF_W-1:0]  off;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;
  logic [TAG_W-1:0]  tag_out;
  logic              err_out;

  modport master (
    output in_valid, din, mode, off, tag_in,
    output out_ready,
    input  in_ready, out_valid, dout,
    input  tag_out, err_out
  );

  modport slave (
    input  in_valid, din, mode, off, tag_in,
    input  out_ready,
    output in_ready, out_valid, dout,
    output tag_out, err_out
  );

endinterface

// File: rtl/ext_core.sv
// Combinational immediate / load-data extender:
// mode and byte offset in, extended word and misalign flag out.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OFF_W  = off_w(DATA_W)
) (
  input  logic [DATA_W-1:0] din,
  input  ext_mode_e         mode,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [IMM_W-1:0]  imm;
  logic [OFF_W+2:0]  bidx;
  logic [OFF_W+2:0]  hidx;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign imm  = din[IMM_W-1:0];
  assign bidx = {off, 3'b000};
  // halfword index drops off[0]; misalignment is flagged, not fixed
  assign hidx = {off[OFF_W-1:1], 4'b0000};
  assign byte_v = din[bidx +: 8];
  assign half_v = din[hidx +: 16];

  always_comb begin
    data = '0;
    err  = 1'b0;
    unique case (mode)
      ZERO: data = {{(DATA_W-IMM_W){1'b0}}, imm};
      SIGN: data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      HIGH: data = {imm, {(DATA_W-IMM_W){1'b0}}};
      LB:   data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LBU:  data = {{(DATA_W-8){1'b0}}, byte_v};
      LH: begin
        data = {{(DATA_W-16){half_v[15]}}, half_v};
        err  = off[0];
      end
      LHU: begin
        data = {{(DATA_W-16){1'b0}}, half_v};
        err  = off[0];
      end
      LW: begin
        data = din;
        err  = (off != '0);
      end
      default: begin
        data = '0;
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ext_stage.sv
// Registered extension stage: extender on the input side feeding
// a 2-entry skid buffer with valid/ready on both ends.
module ext_stage
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  ext_stage_if.slave  bus
);

  localparam int BW = DATA_W + TAG_W + 1;

  buf_state_e        state;
  buf_state_e        state_n;
  logic [DATA_W-1:0] core_data;
  logic              core_err;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     out_q;
  logic [BW-1:0]     skid_q;
  logic              acc;
  logic              cons;
  logic              ld_out;
  logic              ld_skid;
  logic              mv_skid;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .din  (bus.din),
    .mode (bus.mode),
    .off  (bus.off),
    .data (core_data),
    .err  (core_err)
  );

  assign beat = {core_data, bus.tag_in, core_err};

  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.dout      = out_q[BW-1 -: DATA_W];
  assign bus.tag_out   = out_q[TAG_W:1];
  assign bus.err_out   = out_q[0];

  assign acc  = bus.in_valid && bus.in_ready;
  assign cons = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    ld_out  = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_n = ONE;
            ld_out  = 1'b1;
          end
        end
        ONE: begin
          if (acc && cons) begin
            ld_out = 1'b1;
          end else if (acc) begin
            state_n = TWO;
            ld_skid = 1'b1;
          end else if (cons) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (cons) begin
            state_n = ONE;
            mv_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) out_q <= '0;
    else if (ld_out)       out_q <= beat;
    else if (mv_skid)      out_q <= skid_q;
  end

  always_ff @(posedge clk) begin
    if (reset_n && ld_skid) skid_q <= beat;
  end

endmodule

// File: tb/tb_ext_stage.sv
// Directed bench for ext_stage: extension modes, skid-buffer
// stalls, flush/reset drop and a 64-bit instance.
module tb_ext_stage;
  import ext_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic flush64;
  int   n_asrt = 0;
  int   n_fail = 0;

  ext_stage_if #(.DATA_W(32), .TAG_W(5)) bus ();
  ext_stage_if #(.DATA_W(64), .TAG_W(5)) bus64 ();

  ext_stage #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  ext_stage #(.DATA_W(64), .IMM_W(16), .TAG_W(5)) dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush64),
    .bus     (bus64)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input ext_mode_e m, input logic [31:0] d,
                       input logic [1:0] o, input logic [4:0] t);
    bus.mode     = m;
    bus.din      = d;
    bus.off      = o;
    bus.tag_in   = t;
    bus.in_valid = 1'b1;
  endtask

  task automatic beat(input ext_mode_e m, input logic [31:0] d,
                      input logic [1:0] o, input logic [4:0] t);
    drive(m, d, o, t);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic beat64(input ext_mode_e m, input logic [63:0] d,
                        input logic [2:0] o);
    bus64.mode     = m;
    bus64.din      = d;
    bus64.off      = o;
    bus64.tag_in   = 5'd3;
    bus64.in_valid = 1'b1;
    cyc();
    bus64.in_valid = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    flush           = 1'b0;
    flush64         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.din         = '0;
    bus.mode        = ZERO;
    bus.off         = '0;
    bus.tag_in      = '0;
    bus.out_ready   = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.din       = '0;
    bus64.mode      = ZERO;
    bus64.off       = '0;
    bus64.tag_in    = '0;
    bus64.out_ready = 1'b1;

    repeat (2) cyc();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_tag", 64'(bus.tag_out), 64'd0);
    chk("rst_err", 64'(bus.err_out), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;

    beat(SIGN, 32'h1234_8001, 2'd3, 5'd1);
    chk("sign_valid", 64'(bus.out_valid), 64'd1);
    chk("sign_dout", 64'(bus.dout), 64'hFFFF_8001);
    chk("sign_err", 64'(bus.err_out), 64'd0);
    chk("sign_tag", 64'(bus.tag_out), 64'd1);
    beat(ZERO, 32'h1234_8001, 2'd1, 5'd2);
    chk("zero_dout", 64'(bus.dout), 64'h0000_8001);
    chk("zero_tag", 64'(bus.tag_out), 64'd2);
    beat(HIGH, 32'h1234_8001, 2'd2, 5'd3);
    chk("high_dout", 64'(bus.dout), 64'h8001_0000);
    chk("high_err", 64'(bus.err_out), 64'd0);
    beat(LB, 32'h80FF_7F01, 2'd2, 5'd4);
    chk("lb2_dout", 64'(bus.dout), 64'hFFFF_FFFF);
    beat(LB, 32'h80FF_7F01, 2'd1, 5'd5);
    chk("lb1_dout", 64'(bus.dout), 64'h0000_007F);
    beat(LBU, 32'h80FF_7F01, 2'd3, 5'd6);
    chk("lbu3_dout", 64'(bus.dout), 64'h0000_0080);
    beat(LH, 32'h80FF_7F01, 2'd2, 5'd7);
    chk("lh2_dout", 64'(bus.dout), 64'hFFFF_80FF);
    chk("lh2_err", 64'(bus.err_out), 64'd0);
    beat(LH, 32'h80FF_7F01, 2'd0, 5'd8);
    chk("lh0_dout", 64'(bus.dout), 64'h0000_7F01);
    beat(LHU, 32'h80FF_7F01, 2'd1, 5'd9);
    chk("lhu1_dout", 64'(bus.dout), 64'h0000_7F01);
    chk("lhu1_err", 64'(bus.err_out), 64'd1);
    beat(LW, 32'h80FF_7F01, 2'd2, 5'd10);
    chk("lw2_dout", 64'(bus.dout), 64'h80FF_7F01);
    chk("lw2_err", 64'(bus.err_out), 64'd1);
    beat(LW, 32'h80FF_7F01, 2'd0, 5'd11);
    chk("lw0_err", 64'(bus.err_out), 64'd0);
    chk("lw0_tag", 64'(bus.tag_out), 64'd11);
    cyc();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // stalled stream of four beats
    bus.out_ready = 1'b0;
    drive(ZERO, 32'h11, 2'd0, 5'd1);
    cyc();
    chk("s1_valid", 64'(bus.out_valid), 64'd1);
    chk("s1_ready", 64'(bus.in_ready), 64'd1);
    drive(ZERO, 32'h22, 2'd0, 5'd2);
    cyc();
    chk("s2_ready", 64'(bus.in_ready), 64'd0);
    chk("s2_tag", 64'(bus.tag_out), 64'd1);
    drive(ZERO, 32'h33, 2'd0, 5'd3);
    cyc();
    chk("s3_ready", 64'(bus.in_ready), 64'd0);
    chk("s3_tag", 64'(bus.tag_out), 64'd1);
    chk("s3_dout", 64'(bus.dout), 64'h11);
    bus.out_ready = 1'b1;
    cyc();
    chk("s4_tag", 64'(bus.tag_out), 64'd2);
    chk("s4_dout", 64'(bus.dout), 64'h22);
    chk("s4_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("s5_tag", 64'(bus.tag_out), 64'd3);
    chk("s5_dout", 64'(bus.dout), 64'h33);
    drive(ZERO, 32'h44, 2'd0, 5'd4);
    cyc();
    chk("s6_tag", 64'(bus.tag_out), 64'd4);
    chk("s6_dout", 64'(bus.dout), 64'h44);
    bus.in_valid = 1'b0;
    cyc();
    chk("s7_valid", 64'(bus.out_valid), 64'd0);

    // flush while full, with a beat offered on the same edge
    bus.out_ready = 1'b0;
    drive(ZERO, 32'h55, 2'd0, 5'd5);
    cyc();
    drive(ZERO, 32'h66, 2'd0, 5'd6);
    cyc();
    chk("f_full", 64'(bus.in_ready), 64'd0);
    drive(ZERO, 32'h77, 2'd0, 5'd7);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("f_valid", 64'(bus.out_valid), 64'd0);
    chk("f_dout", 64'(bus.dout), 64'd0);
    chk("f_tag", 64'(bus.tag_out), 64'd0);
    chk("f_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("f_dropped", 64'(bus.out_valid), 64'd0);

    // reset while full
    bus.out_ready = 1'b0;
    drive(LW, 32'hAAAA_0001, 2'd1, 5'd8);
    cyc();
    drive(LW, 32'hBBBB_0002, 2'd1, 5'd9);
    cyc();
    chk("r_full", 64'(bus.in_ready), 64'd0);
    chk("r_err_pre", 64'(bus.err_out), 64'd1);
    drive(ZERO, 32'hCC, 2'd0, 5'd10);
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("r_valid", 64'(bus.out_valid), 64'd0);
    chk("r_dout", 64'(bus.dout), 64'd0);
    chk("r_err", 64'(bus.err_out), 64'd0);
    chk("r_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("r_dropped", 64'(bus.out_valid), 64'd0);

    // 64-bit instance
    beat64(LH, 64'h9ABC_1234_5678_0000, 3'd6);
    chk("w64_lh6", bus64.dout, 64'hFFFF_FFFF_FFFF_9ABC);
    chk("w64_lh6_err", 64'(bus64.err_out), 64'd0);
    beat64(LHU, 64'h9ABC_1234_5678_0000, 3'd7);
    chk("w64_lhu7", bus64.dout, 64'h0000_0000_0000_9ABC);
    chk("w64_lhu7_err", 64'(bus64.err_out), 64'd1);
    beat64(LB, 64'h9ABC_1234_5678_0000, 3'd5);
    chk("w64_lb5", bus64.dout, 64'h0000_0000_0000_0012);
    beat64(SIGN, 64'h0000_0000_0000_F00D, 3'd0);
    chk("w64_sign", bus64.dout, 64'hFFFF_FFFF_FFFF_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_stage.md
# ext_stage

Parametrised, registered operand-extension stage for the pipelined CPU datapath. Replaces the purely combinational immediate extender with a multi-mode unit that performs zero, sign and upper-half immediate extension, plus byte/halfword/word extraction and extension of load data by byte offset. Sits between the MEM and WB stages (load path) and feeds the EX operand mux (immediate path). A 2-entry skid buffer with valid/ready handshakes decouples producer and consumer without bubbles.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; multiple of 16, ≥ 32.
- `IMM_W`, 16, immediate field width; < `DATA_W`.
- `TAG_W`, 5, sideband tag width (destination register number).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `flush` in 1: synchronous buffer clear.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: stage can accept a beat.
- `din` in `DATA_W`: immediate in `din[IMM_W-1:0]`, or raw load word.
- `mode` in 3: extension mode, `ext_pkg::ext_mode_e`.
- `off` in `OFF_W = $clog2(DATA_W/8)`: byte offset of the load address.
- `tag_in` in `TAG_W`: sideband, passed through unchanged.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: consumer accepts the beat.
- `dout` out `DATA_W`: extended result.
- `tag_out` out `TAG_W`: tag of the beat on `dout`.
- `err_out` out 1: misaligned access flag for the beat on `dout`.

## Operation
- Modes:
  - `ZERO` (0): `{0, din[IMM_W-1:0]}`.
  - `SIGN` (1): sign-extend `din[IMM_W-1:0]`.
  - `HIGH` (2): `din[IMM_W-1:0] << (DATA_W-IMM_W)`, low bits 0.
  - `LB` / `LBU` (3/4): byte `din[8*off +: 8]`, sign- or zero-extended.
  - `LH` / `LHU` (5/6): half `din[16*off[OFF_W-1:1] +: 16]`, sign- or zero-extended.
  - `LW` (7): `din` unchanged.
- Error rules:
  - `err = 1` for `LH`/`LHU` with `off[0]=1`. Data is still produced using `off[OFF_W-1:1]`.
  - `err = 1` for `LW` with `off ≠ 0`. Data is still `din`.
  - `off` is ignored in immediate modes, and `err = 0`.
- Beats:
  - A beat is accepted on a rising edge with `in_valid && in_ready`.
  - A beat is consumed on a rising edge with `out_valid && out_ready`.
- Skid-buffer states (`ext_pkg::buf_state_e`): `EMPTY`, `ONE`, `TWO`.
  - `EMPTY`: accept → `ONE`.
  - `ONE`: accept only → `TWO`; consume only → `EMPTY`; accept and consume together → `ONE`, with the new beat on the output next cycle.
  - `TWO`: consume → `ONE`, and the held second beat moves to the output register. No accept is possible because `in_ready = 0`.
- Outputs are decoded from registers:
  - `in_ready = (state != TWO)`.
  - `out_valid = (state != EMPTY)`.
- Ordering is strict FIFO. The extension result, tag and error are computed at accept time and stored together with the beat.
- While `out_valid && !out_ready`, `dout`, `tag_out` and `err_out` hold stable.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat per cycle with `out_ready` held high.
- Reset (`reset_n = 0` at an edge):
  - state → `EMPTY`.
  - `out_valid = 0`, `dout = 0`, `tag_out = 0`, `err_out = 0`.
  - `in_ready = 1` from the cycle after the reset edge.
  - Reset mid-transfer discards all buffered beats, with no partial output.
- `flush = 1` at an edge: same effect as reset on state and outputs. A concurrent `in_valid` beat is dropped, and a concurrent `out_ready` is a no-op.
- Reset has priority over `flush`; `flush` has priority over accept/consume.
- Unused data registers hold value, except that the output register clears on reset and flush.

## Structure
- Package `ext_pkg`:
  - `ext_mode_e` (3-bit mode encoding).
  - `buf_state_e`.
  - Localparam helper for `OFF_W`.
- Sub-module `ext_core`: purely combinational mode/offset → `{data, err}` function, parametrised by `DATA_W` and `IMM_W`. It is instantiated once, on the input side.
- `ext_stage` contains only the skid buffer, the state register and the handshake logic.

## Test plan
- `SIGN`, `din[15:0]=16'h8001`, `out_ready=1` → next cycle `dout=32'hFFFF8001`, `err_out=0`. `ZERO` on the same input → `32'h00008001`. `HIGH` → `32'h80010000`.
- `LB`, `din=32'h80FF7F01`, `off=2` → `32'hFFFFFFFF`. `LBU` `off=3` → `32'h00000080`. `LH` `off=2` → `32'hFFFF80FF`.
- `LHU` `off=1` → `err_out=1`, `dout=32'h00007F01`. `LW` `off=2` → `err_out=1`, `dout=din`.
- Stream 4 beats with `out_ready` low for cycles 2–3:
  - state reaches `TWO`, `in_ready=0`, and the third beat stalls.
  - On release, beats emerge in order with tags 1,2,3,4 and none lost or duplicated.
- Assert `flush` (then, separately, `reset_n=0`) while in `TWO`, with `in_valid=1` on the same edge → next cycle `out_valid=0`, `dout=0`, `in_ready=1`, and the dropped beat never appears.
- Parameter sweep: `DATA_W=64`, `IMM_W=16`, `LH` `off=6` → extracts `din[63:48]` and sign-extends it to 64 bits.
